// File: rtl/chunk_sched_pkg.sv
// chunk_sched_pkg: chunk sizes, derived widths and read-FSM states shared by the chunk scheduler
package chunk_sched_pkg;
    localparam int WR_CYC_NUM    = 4;
    localparam int RD_CYC_NUM    = 16;
    localparam int MAX_SUB_CHUNK = 16;
    localparam int WR_CNT_W      = $clog2(WR_CYC_NUM);
    localparam int RD_ADDR_W     = $clog2(RD_CYC_NUM);
    localparam int SUB_W         = $clog2(MAX_SUB_CHUNK) + 1;
    localparam int LEN_W         = $clog2(RD_CYC_NUM) + 1;
    typedef enum logic [1:0] {IDLE, START, RUN, RELEASE} state_e;
endpackage

// File: rtl/chunk_wr_ctrl.sv
// chunk_wr_ctrl: write-side beat counter and ping-pong select, flags a buffer full on its last beat
module chunk_wr_ctrl
    import chunk_sched_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                wr_valid_i,
    input  logic [1:0]          full_i,
    output logic                wr_ready_o,
    output logic                chunk_wr_valid_o,
    output logic [WR_CNT_W-1:0] chunk_wr_count_o,
    output logic                chunk_wr_sel_o,
    output logic                set_full_o
);
    logic [WR_CNT_W-1:0] wr_cnt_q;
    logic                wr_sel_q;
    logic                beat_last;
    assign wr_ready_o       = !full_i[wr_sel_q];
    assign chunk_wr_valid_o = wr_valid_i && wr_ready_o;
    assign chunk_wr_count_o = wr_cnt_q;
    assign chunk_wr_sel_o   = wr_sel_q;
    assign beat_last        = wr_cnt_q == WR_CNT_W'(WR_CYC_NUM - 1);
    assign set_full_o       = chunk_wr_valid_o && beat_last;
    // step the beat index on accepted beats; the last beat wraps it and hands over to the other buffer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_cnt_q <= '0;
            wr_sel_q <= 1'b0;
        end else if (chunk_wr_valid_o) begin
            wr_cnt_q <= beat_last ? '0 : wr_cnt_q + WR_CNT_W'(1);
            wr_sel_q <= wr_sel_q ^ beat_last;
        end
    end
endmodule

// File: rtl/chunk_sched.sv
// chunk_sched: ping-pong chunk scheduler; optional read-starvation counter under CHUNK_SCHED_STALL_CNT_EN
module chunk_sched
    import chunk_sched_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [SUB_W-1:0]     cfg_sub_chunk_num_i,
    input  logic [LEN_W-1:0]     cfg_sub_chunk_len_i,
    input  logic                 wr_valid_i,
    output logic                 wr_ready_o,
    output logic                 chunk_wr_valid_o,
    output logic [WR_CNT_W-1:0]  chunk_wr_count_o,
    output logic                 chunk_wr_sel_o,
    output logic                 chunk_rd_sel_o,
    output logic                 sub_chunk_start_o,
    output logic                 run_valid_o,
    output logic [RD_ADDR_W-1:0] rd_fil_sparsemap_first_o,
    output logic [RD_ADDR_W-1:0] rd_fil_sparsemap_last_o,
    input  logic                 sub_chunk_end_i,
    output logic                 chunk_done_o,
    output logic                 busy_o
`ifdef CHUNK_SCHED_STALL_CNT_EN
    ,
    input  logic                 stall_cnt_clr_i,
    output logic [31:0]          stall_cnt_o
`endif
);
    state_e               state_q, state_d;
    logic [1:0]           full_q, full_d;
    logic                 rd_sel_q;
    logic                 set_full;
    logic                 load_start;
    logic                 release_buf;
    logic [SUB_W-1:0]     num_q, sub_idx_q, sub_idx_d, cfg_num;
    logic [LEN_W-1:0]     len_q, len_d, cfg_len;
    logic [RD_ADDR_W-1:0] first_q, last_q, first_d, last_d;

    chunk_wr_ctrl u_wr_ctrl (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .wr_valid_i       (wr_valid_i),
        .full_i           (full_q),
        .wr_ready_o       (wr_ready_o),
        .chunk_wr_valid_o (chunk_wr_valid_o),
        .chunk_wr_count_o (chunk_wr_count_o),
        .chunk_wr_sel_o   (chunk_wr_sel_o),
        .set_full_o       (set_full)
    );

    assign cfg_num    = (cfg_sub_chunk_num_i == '0) ? SUB_W'(1) : cfg_sub_chunk_num_i;
    assign cfg_len    = (cfg_sub_chunk_len_i == '0) ? LEN_W'(RD_CYC_NUM) : cfg_sub_chunk_len_i;
    assign load_start = state_d == START;
    // RD_CYC_NUM is a power of two, so the modulo is plain truncation to the address width
    assign first_d    = RD_ADDR_W'(sub_idx_d) * RD_ADDR_W'(len_d);
    assign last_d     = first_d + RD_ADDR_W'(len_d - LEN_W'(1));

    assign chunk_rd_sel_o           = rd_sel_q;
    assign sub_chunk_start_o        = state_q == START;
    assign run_valid_o              = (state_q == START) || (state_q == RUN);
    assign chunk_done_o             = state_q == RELEASE;
    assign busy_o                   = state_q != IDLE;
    assign rd_fil_sparsemap_first_o = first_q;
    assign rd_fil_sparsemap_last_o  = last_q;

    // read FSM: wait for a full buffer, walk its sub-chunks, then release it
    always_comb begin
        state_d     = state_q;
        release_buf = 1'b0;
        sub_idx_d   = sub_idx_q + SUB_W'(1);
        len_d       = len_q;
        case (state_q)
            IDLE: begin
                sub_idx_d = '0;
                len_d     = cfg_len;
                state_d   = full_q[rd_sel_q] ? START : IDLE;
            end
            START:   state_d = RUN;
            RUN:     state_d = !sub_chunk_end_i ? RUN : (sub_idx_q == num_q - SUB_W'(1)) ? RELEASE : START;
            RELEASE: begin
                release_buf = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // buffer occupancy: the writer sets one buffer while a release may clear the other in the same cycle
    always_comb begin
        full_d = full_q;
        if (set_full) full_d[chunk_wr_sel_o] = 1'b1;
        if (release_buf) full_d[rd_sel_q] = 1'b0;
    end

    // state, occupancy, cfg snapshot taken while idle, and sub-chunk addresses captured on entry to START
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            full_q    <= 2'b00;
            rd_sel_q  <= 1'b0;
            num_q     <= '0;
            len_q     <= '0;
            sub_idx_q <= '0;
            first_q   <= '0;
            last_q    <= '0;
        end else begin
            state_q  <= state_d;
            full_q   <= full_d;
            rd_sel_q <= rd_sel_q ^ release_buf;
            if (state_q == IDLE) begin
                num_q <= cfg_num;
                len_q <= cfg_len;
            end
            if (load_start) begin
                sub_idx_q <= sub_idx_d;
                first_q   <= first_d;
                last_q    <= last_d;
            end
        end
    end

`ifdef CHUNK_SCHED_STALL_CNT_EN
    logic [31:0] stall_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
    // saturating count of idle cycles with nothing to read; a clear wins over a count
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) stall_cnt_q <= '0;
        else if (stall_cnt_clr_i) stall_cnt_q <= '0;
        else if (state_q == IDLE && !full_q[rd_sel_q] && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
`endif
endmodule

// File: tb/tb_chunk_sched.sv
// tb_chunk_sched: scoreboard bench for chunk_sched; stall counter checks only when CHUNK_SCHED_STALL_CNT_EN is defined
module tb_chunk_sched;
    import chunk_sched_pkg::*;
    logic                 clk_i = 1'b0;
    logic                 rst_ni = 1'b0;
    logic [SUB_W-1:0]     cfg_sub_chunk_num_i = '0;
    logic [LEN_W-1:0]     cfg_sub_chunk_len_i = '0;
    logic                 wr_valid_i = 1'b0;
    logic                 sub_chunk_end_i = 1'b0;
    logic                 wr_ready_o, chunk_wr_valid_o, chunk_wr_sel_o, chunk_rd_sel_o;
    logic                 sub_chunk_start_o, run_valid_o, chunk_done_o, busy_o;
    logic [WR_CNT_W-1:0]  chunk_wr_count_o;
    logic [RD_ADDR_W-1:0] rd_fil_sparsemap_first_o, rd_fil_sparsemap_last_o;
`ifdef CHUNK_SCHED_STALL_CNT_EN
    logic                 stall_cnt_clr_i = 1'b0;
    logic [31:0]          stall_cnt_o;
`endif
    int errors = 0;
    int checks = 0;
    int n_done = 0;
    logic [2:0] wr_q[$];
    logic [7:0] st_q[$];
    logic       dn_q[$];

    always #5 clk_i = ~clk_i;

    chunk_sched dut (
        .clk_i                    (clk_i),
        .rst_ni                   (rst_ni),
        .cfg_sub_chunk_num_i      (cfg_sub_chunk_num_i),
        .cfg_sub_chunk_len_i      (cfg_sub_chunk_len_i),
        .wr_valid_i               (wr_valid_i),
        .wr_ready_o               (wr_ready_o),
        .chunk_wr_valid_o         (chunk_wr_valid_o),
        .chunk_wr_count_o         (chunk_wr_count_o),
        .chunk_wr_sel_o           (chunk_wr_sel_o),
        .chunk_rd_sel_o           (chunk_rd_sel_o),
        .sub_chunk_start_o        (sub_chunk_start_o),
        .run_valid_o              (run_valid_o),
        .rd_fil_sparsemap_first_o (rd_fil_sparsemap_first_o),
        .rd_fil_sparsemap_last_o  (rd_fil_sparsemap_last_o),
        .sub_chunk_end_i          (sub_chunk_end_i),
        .chunk_done_o             (chunk_done_o),
        .busy_o                   (busy_o)
`ifdef CHUNK_SCHED_STALL_CNT_EN
        ,
        .stall_cnt_clr_i          (stall_cnt_clr_i),
        .stall_cnt_o              (stall_cnt_o)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: DUT pulsed with nothing expected", name);
    endtask

    // monitor: pops the scoreboard whenever the DUT presents a write, a start or a done
    initial forever begin
        @(negedge clk_i);
        if (chunk_wr_valid_o) begin
            if (wr_q.size() == 0) unexpected("write_beat");
            else chk("write_beat sel/count", 32'({chunk_wr_sel_o, chunk_wr_count_o}), 32'(wr_q.pop_front()));
        end
        if (sub_chunk_start_o) begin
            if (st_q.size() == 0) unexpected("sub_chunk_start");
            else chk("start first/last", 32'({rd_fil_sparsemap_first_o, rd_fil_sparsemap_last_o}), 32'(st_q.pop_front()));
        end
        if (chunk_done_o) begin
            n_done++;
            if (dn_q.size() == 0) unexpected("chunk_done");
            else chk("done rd_sel", 32'(chunk_rd_sel_o), 32'(dn_q.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic beats(input int n);
        wr_valid_i = 1'b1;
        repeat (n) @(posedge clk_i);
        #1 wr_valid_i = 1'b0;
    endtask

    task automatic wait_evt(input int kind, input string name);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk_i);
            if ((kind == 0 && sub_chunk_start_o) || (kind == 1 && chunk_done_o)) return;
        end
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting for event, expected within 64 cycles", name);
    endtask

    task automatic end_pulse();
        @(posedge clk_i);
        #1 sub_chunk_end_i = 1'b1;
        @(posedge clk_i);
        #1 sub_chunk_end_i = 1'b0;
    endtask

    task automatic push_chunk_writes(input logic sel);
        for (int i = 0; i < WR_CYC_NUM; i++) wr_q.push_back({sel, WR_CNT_W'(i)});
    endtask

    initial begin
        // reset values
        repeat (3) @(negedge clk_i);
        chk("rst wr_ready", 32'(wr_ready_o), 1);
        chk("rst run_valid", 32'(run_valid_o), 0);
        chk("rst busy", 32'(busy_o), 0);
        chk("rst start", 32'(sub_chunk_start_o), 0);
        chk("rst done", 32'(chunk_done_o), 0);
        chk("rst wr_sel", 32'(chunk_wr_sel_o), 0);
        chk("rst rd_sel", 32'(chunk_rd_sel_o), 0);
        chk("rst last", 32'(rd_fil_sparsemap_last_o), 0);
        // chunk 1: num=0 (->1), len=0 (->16)
        cfg_sub_chunk_num_i = 5'd0;
        cfg_sub_chunk_len_i = 5'd0;
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        push_chunk_writes(1'b0);
        st_q.push_back({4'd0, 4'd15});
        dn_q.push_back(1'b0);
        beats(4);
        chk("s1 wr_sel toggled", 32'(chunk_wr_sel_o), 1);
        @(negedge clk_i);
        chk("s1 no start yet", 32'(sub_chunk_start_o), 0);
        @(negedge clk_i);
        chk("s1 start latency", 32'(sub_chunk_start_o), 1);
        @(negedge clk_i);
        chk("s1 run_valid", 32'(run_valid_o), 1);
        chk("s1 busy", 32'(busy_o), 1);
        repeat (3) @(negedge clk_i);
        chk("s1 run_valid held", 32'(run_valid_o), 1);
        end_pulse();
        wait_evt(1, "s1 done");
        chk("s1 run_valid off in release", 32'(run_valid_o), 0);
        @(negedge clk_i);
        chk("s1 rd_sel after done", 32'(chunk_rd_sel_o), 1);
        chk("s1 idle after done", 32'(busy_o), 0);
        // chunk 2: four sub-chunks of 4
        cfg_sub_chunk_num_i = 5'd4;
        cfg_sub_chunk_len_i = 5'd4;
        push_chunk_writes(1'b1);
        st_q.push_back({4'd0, 4'd3});
        st_q.push_back({4'd4, 4'd7});
        st_q.push_back({4'd8, 4'd11});
        st_q.push_back({4'd12, 4'd15});
        dn_q.push_back(1'b1);
        @(posedge clk_i);
        #1;
        beats(4);
        wait_evt(0, "s2 first start");
        for (int k = 0; k < 4; k++) begin
            end_pulse();
            wait_evt(k < 3 ? 0 : 1, "s2 next event");
        end
        // two chunks back to back with no end pulses: writer must stall
        cfg_sub_chunk_num_i = 5'd1;
        cfg_sub_chunk_len_i = 5'd8;
        push_chunk_writes(1'b0);
        push_chunk_writes(1'b1);
        st_q.push_back({4'd0, 4'd7});
        st_q.push_back({4'd0, 4'd7});
        st_q.push_back({4'd8, 4'd15});
        dn_q.push_back(1'b0);
        dn_q.push_back(1'b1);
        @(posedge clk_i);
        #1 wr_valid_i = 1'b1;
        repeat (8) @(posedge clk_i);
        #1;
        @(negedge clk_i);
        chk("s3 wr_ready both full", 32'(wr_ready_o), 0);
        chk("s3 ninth beat rejected", 32'(chunk_wr_valid_o), 0);
        @(posedge clk_i);
        #1 wr_valid_i = 1'b0;
        cfg_sub_chunk_num_i = 5'd2;
        end_pulse();
        wait_evt(1, "s3 done");
        chk("s3 wr_ready during release", 32'(wr_ready_o), 0);
        @(negedge clk_i);
        chk("s3 wr_ready after release", 32'(wr_ready_o), 1);
        // end pulse held across IDLE and START must be ignored; cfg change mid-chunk ignored
        sub_chunk_end_i = 1'b1;
        wait_evt(0, "s4 start");
        cfg_sub_chunk_num_i = 5'd1;
        cfg_sub_chunk_len_i = 5'd4;
        @(posedge clk_i);
        #1 sub_chunk_end_i = 1'b0;
        @(negedge clk_i);
        chk("s4 still running", 32'(run_valid_o), 1);
        chk("s4 no done", 32'(chunk_done_o), 0);
        repeat (3) @(negedge clk_i);
        chk("s4 run held", 32'(busy_o), 1);
        end_pulse();
        wait_evt(0, "s4 second start");
        end_pulse();
        wait_evt(1, "s4 done");
        // reset during RUN with both buffers full
        push_chunk_writes(1'b0);
        push_chunk_writes(1'b1);
        st_q.push_back({4'd0, 4'd3});
        @(posedge clk_i);
        #1;
        beats(8);
        repeat (2) @(negedge clk_i);
        chk("s5 running", 32'(run_valid_o), 1);
        chk("s5 both full", 32'(wr_ready_o), 0);
        chk("s5 last", 32'(rd_fil_sparsemap_last_o), 3);
        @(posedge clk_i);
        #1 rst_ni = 1'b0;
        #1;
        chk("s5 rst run_valid", 32'(run_valid_o), 0);
        chk("s5 rst busy", 32'(busy_o), 0);
        chk("s5 rst wr_ready", 32'(wr_ready_o), 1);
        chk("s5 rst last", 32'(rd_fil_sparsemap_last_o), 0);
        chk("s5 rst wr_sel", 32'(chunk_wr_sel_o), 0);
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        repeat (5) @(negedge clk_i);
        chk("s5 idle after reset", 32'(busy_o), 0);
        chk("s5 wr_ready after reset", 32'(wr_ready_o), 1);
`ifdef CHUNK_SCHED_STALL_CNT_EN
        @(posedge clk_i);
        #1 stall_cnt_clr_i = 1'b1;
        @(posedge clk_i);
        #1 stall_cnt_clr_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1;
        chk("stall count", stall_cnt_o, 10);
        stall_cnt_clr_i = 1'b1;
        @(posedge clk_i);
        #1 stall_cnt_clr_i = 1'b0;
        chk("stall clear priority", stall_cnt_o, 0);
`endif
        repeat (5) @(negedge clk_i);
        chk("wr queue drained", 32'(wr_q.size()), 0);
        chk("start queue drained", 32'(st_q.size()), 0);
        chk("done queue drained", 32'(dn_q.size()), 0);
        chk("done pulse total", 32'(n_done), 4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
